// File: rtl/pe_array_pkg.sv
// Shared constants and helpers for the PE array result path.
// Ports: none (package).
// Provides PSUM_W/ACT_W widths and a constant-foldable clog2.
package pe_array_pkg;

  localparam int PSUM_W = 32;
  localparam int ACT_W  = 8;

  // Ceiling log2; usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_sync_fifo.sv
// First-word-fall-through synchronous FIFO for aligned psum vectors.
// Ports: i_clk/i_rst (async active-high), i_push/i_dat write side, i_pop read side,
//        o_dat head (or last popped word when empty), o_empty/o_full/o_count status.
module psum_sync_fifo
  import pe_array_pkg::*;
#(
  parameter  int WIDTH = PSUM_W,
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_hold;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage needs no reset: nothing is read from it until it has been written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty the output keeps showing the most recently popped word.
  assign o_dat   = w_empty ? r_hold : r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;

endmodule

// File: rtl/psum_drain_collector.sv
// Deskews the PE array's column-skewed psum bus into whole row vectors and queues them
// for a valid/ready consumer. Ports: CLK/RESET/EN, in_tag + out_sum_final from the array,
// m_valid/m_ready/m_data stream out, fifo_count, sticky overflow with clr_overflow.
module psum_drain_collector
  import pe_array_pkg::*;
#(
  parameter int NUM_COLS   = 32,
  parameter int ARRAY_LAT  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         EN,
  input  logic                         in_tag,
  input  logic [NUM_COLS*PSUM_W-1:0]   out_sum_final,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_COLS*PSUM_W-1:0]   m_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  // Tag travels the array latency plus the widest column skew.
  localparam int L = ARRAY_LAT + NUM_COLS - 1;

  logic [L-1:0]                w_tag_q;
  logic [L-1:0]                w_tag_in;
  logic [PSUM_W-1:0]           w_aligned_col [NUM_COLS];
  logic [NUM_COLS*PSUM_W-1:0]  w_aligned_vec;
  logic                        w_aligned_vld;
  logic                        w_fifo_empty;
  logic                        w_fifo_full;
  logic                        w_pop;
  logic                        w_drop;
  logic                        r_overflow;

  // ---------------- tag pipe ----------------
  assign w_tag_in = {w_tag_q[L-2:0], in_tag};

  for (genvar s = 0; s < L; s++) begin : g_tag
    logic r_stage;
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)   r_stage <= 1'b0;
      else if (EN) r_stage <= w_tag_in[s];
    end
    assign w_tag_q[s] = r_stage;
  end

  // ---------------- deskew triangle ----------------
  // Column c arrives c EN-cycles after column 0, so it is delayed by the
  // remaining NUM_COLS-1-c stages; the last column is used straight off the bus.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_deskew
    localparam int D = NUM_COLS - 1 - c;
    if (D == 0) begin : g_wire
      assign w_aligned_col[c] = out_sum_final[c*PSUM_W +: PSUM_W];
    end else begin : g_regs
      logic [PSUM_W-1:0] r_dly [D];
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          for (int k = 0; k < D; k++) r_dly[k] <= '0;
        end else if (EN) begin
          r_dly[0] <= out_sum_final[c*PSUM_W +: PSUM_W];
          for (int k = 1; k < D; k++) r_dly[k] <= r_dly[k-1];
        end
      end
      assign w_aligned_col[c] = r_dly[D-1];
    end
  end

  always_comb begin
    w_aligned_vec = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      w_aligned_vec[c*PSUM_W +: PSUM_W] = w_aligned_col[c];
    end
  end

  // Columns line up only on an EN cycle; on EN=0 the array is frozen.
  assign w_aligned_vld = w_tag_q[L-1] & EN;

  // ---------------- output FIFO ----------------
  assign m_valid = ~w_fifo_empty;
  assign w_pop   = m_valid & m_ready;
  // The array cannot stall: a vector arriving at a full FIFO with no
  // simultaneous pop is lost.
  assign w_drop  = w_aligned_vld & w_fifo_full & ~w_pop;

  psum_sync_fifo #(
    .WIDTH (NUM_COLS*PSUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_aligned_vld),
    .i_dat   (w_aligned_vec),
    .i_pop   (m_ready),
    .o_dat   (m_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (fifo_count)
  );

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)             r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (clr_overflow) r_overflow <= 1'b0;
  end

  assign overflow = r_overflow;

endmodule

// File: tb/tb_psum_drain_collector.sv
module tb_psum_drain_collector;

  localparam int NC = 32;
  localparam int AL = 32;
  localparam int FD = 16;
  localparam int L  = AL + NC - 1;
  localparam int W  = NC * 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          EN = 1'b0;
  logic          in_tag = 1'b0;
  logic          m_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [W-1:0]  out_sum_final = '0;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic [4:0]    fifo_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  psum_drain_collector #(.NUM_COLS(NC), .ARRAY_LAT(AL), .FIFO_DEPTH(FD)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .EN            (EN),
    .in_tag        (in_tag),
    .out_sum_final (out_sum_final),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow)
  );

  // ---------------- behavioural model ----------------
  // vmap: vectors keyed by the EN-cycle index at which their tag was taken.
  logic [W-1:0] vmap [int];
  logic [W-1:0] q [$];
  logic [W-1:0] last_dat = '0;
  logic [W-1:0] cur_vec  = '0;
  bit           m_ovf = 1'b0;
  bit           drop;
  int           en_cnt = 0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q.delete();
      vmap.delete();
      last_dat = '0;
      m_ovf    = 1'b0;
    end else begin
      drop = 1'b0;
      if (q.size() > 0 && m_ready) last_dat = q.pop_front();
      if (EN && vmap.exists(en_cnt - L)) begin
        if (q.size() < FD) q.push_back(vmap[en_cnt - L]);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (EN && in_tag) vmap[en_cnt] = cur_vec;
      if (EN) en_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_dat(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    int col;
    col = -1;
    total++;
    for (int c = NC - 1; c >= 0; c--) if (act[c*32 +: 32] !== exp[c*32 +: 32]) col = c;
    if (col >= 0) begin
      bad++;
      $display("FAIL %s col %0d: got %h want %h", nm, col, act[col*32 +: 32], exp[col*32 +: 32]);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (!RESET) begin
      chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk_dat("m_data", m_data, (q.size() != 0) ? q[0] : last_dat);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [W-1:0] mkv(input int base);
    logic [W-1:0] v;
    for (int c = 0; c < NC; c++) v[c*32 +: 32] = 32'(base + c);
    return v;
  endfunction

  function automatic logic [W-1:0] rvec();
    logic [W-1:0] v;
    for (int c = 0; c < NC; c++) v[c*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle of stimulus. The bus mimics the array: column c carries the
  // vector tagged AL+c EN-cycles earlier, otherwise junk.
  task automatic cyc(input bit en, input bit tag, input bit rdy, input bit clr, input logic [W-1:0] vec);
    @(posedge CLK);
    #1;
    EN = en;
    in_tag = tag;
    m_ready = rdy;
    clr_overflow = clr;
    cur_vec = vec;
    for (int c = 0; c < NC; c++) begin
      int src;
      src = en_cnt - AL - c;
      if (en && vmap.exists(src)) out_sum_final[c*32 +: 32] = vmap[src][c*32 +: 32];
      else out_sum_final[c*32 +: 32] = $urandom;
    end
  endtask

  task automatic do_reset();
    EN = 1'b0; in_tag = 1'b0; m_ready = 1'b0; clr_overflow = 1'b0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, nb, last;
    bit rdy;

    // Reset state
    #3;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk_dat("rst_data", m_data, '0);
    do_reset();

    // 1) single tag, column c = 100+c
    got = -1; nb = 0;
    for (int i = 0; i < L + 10; i++) begin
      cyc(1, i == 0, 1, 0, mkv(100));
      @(negedge CLK);
      if (m_valid) begin
        if (got < 0) begin
          got = i;
          chk_dat("t1_data", m_data, mkv(100));
        end
        nb++;
      end
    end
    chk("t1_latency", got, L + 1);
    chk("t1_beats", nb, 1);

    // 2) 8 back-to-back tags, signed distinct values
    do_reset();
    got = -1; nb = 0; last = -1;
    for (int i = 0; i < L + 14; i++) begin
      cyc(1, i < 8, 1, 0, mkv(-1000 * (i + 1)));
      @(negedge CLK);
      if (m_valid) begin
        if (got < 0) got = i;
        chk("t2_col5", m_data[5*32 +: 32], 32'(-1000 * (nb + 1) + 5));
        nb++;
        last = i;
      end
    end
    chk("t2_first", got, L + 1);
    chk("t2_last", last, L + 8);
    chk("t2_beats", nb, 8);

    // 3) EN dropped twice during flight
    do_reset();
    got = -1;
    for (int i = 0; i < L + 12; i++) begin
      cyc(!(i == 3 || i == 5), i == 0, 1, 0, mkv(777));
      @(negedge CLK);
      if (m_valid && got < 0) begin
        got = i;
        chk_dat("t3_data", m_data, mkv(777));
      end
    end
    chk("t3_latency", got, L + 3);

    // 4) 20 tags into a stalled FIFO
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, mkv(5000 + 100 * i));
    for (int i = 0; i < L + 5; i++) cyc(1, 0, 0, 0, '0);
    @(negedge CLK);
    chk("t4_count", 32'(fifo_count), 32'd16);
    chk("t4_ovf", 32'(overflow), 32'd1);
    nb = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1, 0, 1, 0, '0);
      @(negedge CLK);
      if (m_valid) begin
        chk("t4_col0", m_data[31:0], 32'(5000 + 100 * nb));
        nb++;
      end
    end
    chk("t4_beats", nb, 16);

    // 5) full FIFO: push+pop together, then drop, clear, drop-vs-clear
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, mkv(9000 + 100 * i));
    for (int i = 0; i < L + 3; i++) cyc(1, 0, 0, 0, '0);
    @(negedge CLK);
    chk("t5_fill", 32'(fifo_count), 32'd16);
    for (int i = 0; i <= L + 1; i++) cyc(1, i == 0, i == L, 0, mkv(42));
    @(negedge CLK);
    chk("t5_pp_count", 32'(fifo_count), 32'd16);
    chk("t5_pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i <= L + 1; i++) cyc(1, i == 0, 0, 0, mkv(43));
    @(negedge CLK);
    chk("t5_drop_ovf", 32'(overflow), 32'd1);
    chk("t5_drop_count", 32'(fifo_count), 32'd16);
    cyc(1, 0, 0, 1, '0);
    cyc(1, 0, 0, 0, '0);
    @(negedge CLK);
    chk("t5_clr", 32'(overflow), 32'd0);
    for (int i = 0; i <= L + 1; i++) cyc(1, i == 0, 0, i == L, mkv(44));
    @(negedge CLK);
    chk("t5_drop_wins", 32'(overflow), 32'd1);

    // 6) async reset with 5 queued and 3 in flight
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, mkv(300 + 100 * i));
    for (int i = 0; i < L + 3; i++) cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, mkv(900 + 100 * i));
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, '0);
    @(negedge CLK);
    chk("t6_queued", 32'(fifo_count), 32'd5);
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk_dat("t6_data", m_data, '0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    nb = 0;
    for (int i = 0; i < L + 20; i++) begin
      cyc(1, 0, 1, 0, '0);
      @(negedge CLK);
      if (m_valid) nb++;
    end
    chk("t6_beats", nb, 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 900; i++) begin
      if ((i % 300) < 120) rdy = ($urandom_range(0, 3) == 0);
      else rdy = ($urandom_range(0, 9) < 8);
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0, rdy,
          $urandom_range(0, 15) == 0, rvec());
    end
    for (int i = 0; i < L + 40; i++) cyc(1, 0, 1, 0, '0);
    @(negedge CLK);
    chk("rand_drained", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
